// File: rtl/seg7_capture.sv
// Captures a multiplexed active-low 7-segment display bus into per-digit BCD codes.
// A segment/enable sample is accepted only after it has been stable for STABLE_CNT samples.
module seg7_capture #(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [6:0]  iSEG7,
    input  logic [3:0]  iDIG_N,
    input  logic        iCLR,
    output logic [15:0] oBCD,
    output logic [3:0]  oVALID,
    output logic        oUPD,
    output logic        oERR
);

    localparam logic [7:0] CntMax = 8'(STABLE_CNT);

    logic [6:0] sampSeg;
    logic [3:0] sampDig;
    logic [6:0] heldSeg;
    logic [3:0] heldDig;
    logic [7:0] runCnt;

    logic [7:0] runCntNext;
    logic       accept;
    logic       digLegal;
    logic [1:0] digIdx;
    logic       codeOk;
    logic [3:0] code;

    // The run counter compares the freshly registered sample against the one before it.
    always_comb begin
        if ({sampSeg, sampDig} != {heldSeg, heldDig}) begin
            runCntNext = 8'd1;
        end else if (runCnt == CntMax) begin
            runCntNext = runCnt;
        end else begin
            runCntNext = runCnt + 8'd1;
        end
        accept = (runCntNext == CntMax) && (runCnt != CntMax);
    end

    always_comb begin
        digLegal = 1'b1;
        digIdx   = 2'd0;
        case (sampDig)
            4'b1110: digIdx = 2'd0;
            4'b1101: digIdx = 2'd1;
            4'b1011: digIdx = 2'd2;
            4'b0111: digIdx = 2'd3;
            default: digLegal = 1'b0;
        endcase
    end

    // Pattern bits are {g,f,e,d,c,b,a}, a lit segment is 0.
    always_comb begin
        codeOk = 1'b1;
        code   = 4'hF;
        case (sampSeg)
            7'b1000000: code = 4'h0;
            7'b1111001: code = 4'h1;
            7'b0100100: code = 4'h2;
            7'b0110000: code = 4'h3;
            7'b0011001: code = 4'h4;
            7'b0010010: code = 4'h5;
            7'b0000010: code = 4'h6;
            7'b1111000: code = 4'h7;
            7'b0000000: code = 4'h8;
            7'b0010000: code = 4'h9;
            7'b1111111: code = 4'hF;
            default:    codeOk = 1'b0;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            sampSeg <= 7'b1111111;
            sampDig <= 4'b1111;
            heldSeg <= 7'b1111111;
            heldDig <= 4'b1111;
            runCnt  <= 8'd0;
            oBCD    <= 16'hFFFF;
            oVALID  <= 4'b0000;
            oUPD    <= 1'b0;
            oERR    <= 1'b0;
        end else begin
            sampSeg <= iSEG7;
            sampDig <= iDIG_N;
            heldSeg <= sampSeg;
            heldDig <= sampDig;
            oUPD    <= 1'b0;
            if (iCLR) begin
                runCnt <= 8'd0;
                oBCD   <= 16'hFFFF;
                oVALID <= 4'b0000;
                oERR   <= 1'b0;
            end else begin
                runCnt <= runCntNext;
                if (accept && digLegal) begin
                    if (codeOk) begin
                        oBCD[{digIdx, 2'b00} +: 4] <= code;
                        oVALID[digIdx]             <= 1'b1;
                        oUPD                       <= 1'b1;
                    end else begin
                        oERR <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 SHALL have parameter: STABLE_CNT, 4, consecutive identical samples required before a segment/enable sample is accepted (legal range 2..255).
REQ-002 SHALL have port: iCLK  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: iRST_N  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port: iSEG7  input  7  active-low segment pattern, bit0 = segment a ... bit6 = segment g.
REQ-005 SHALL have port: iDIG_N  input  4  active-low digit enables; iDIG_N[k]=0 selects display digit k.
REQ-006 SHALL have port: iCLR  input  1  synchronous clear of captured state, active-high.
REQ-007 SHALL have port: oBCD  output  16  captured digits; digit k at oBCD[4k+3:4k].
REQ-008 SHALL have port: oVALID  output  4  per-digit flag, 1 = digit k holds an accepted value.
REQ-009 SHALL have port: oUPD  output  1  one-cycle pulse, a digit was written.
REQ-010 SHALL have port: oERR  output  1  sticky flag, an accepted sample carried an undecodable pattern.

Function
REQ-011 SHALL register iSEG7 and iDIG_N into a sample register every cycle, with no other logic ahead of it.
REQ-012 SHALL maintain a run counter: set to 1 when the new sample differs from the held sample, else increment, saturating at STABLE_CNT.
REQ-013 SHALL accept a sample exactly once per run, in the cycle the counter reaches STABLE_CNT; a run ends only when the sample changes.
REQ-014 SHALL give latency STABLE_CNT+1 clock edges from the first edge an input value is presented until outputs reflect it.
REQ-015 SHALL ignore an accepted sample whose iDIG_N does not have exactly one zero bit (no write, no oUPD, no oERR).
REQ-016 SHALL decode an accepted pattern: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 1111111->4'hF (blank).
REQ-017 SHALL, for a decodable pattern on a legal enable, write the code into digit k, set oVALID[k], and pulse oUPD for exactly one cycle.
REQ-018 SHALL pulse oUPD on every such write, even if the value is unchanged.
REQ-019 SHALL, for any pattern not in REQ-016 on a legal enable, leave oBCD and oVALID unchanged and set oERR.
REQ-020 SHALL hold oERR at 1 until iCLR or reset.
REQ-021 SHALL, on iCLR=1, set oBCD=16'hFFFF, oVALID=4'b0000, oERR=0, oUPD=0, and run counter=0.
REQ-022 SHALL, when iCLR coincides with an acceptance, drop the acceptance with no write and no oUPD.
REQ-023 SHALL apply priority: reset > iCLR > acceptance.
REQ-024 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-025 SHALL, while iRST_N=0 at a clock edge, set oBCD=16'hFFFF, oVALID=4'b0000, oUPD=0, oERR=0, run counter=0, and sample register to iSEG7=7'b1111111, iDIG_N=4'b1111.
REQ-026 SHALL abandon any partial run on reset; a run starts fresh after iRST_N returns high.

Verification (STABLE_CNT=4)
REQ-027 SHALL cover: after reset, iDIG_N=4'b1110, iSEG7=7'b0100100 held 10 cycles -> on edge 5, oBCD[3:0]=4'h2, oVALID=4'b0001, and a single oUPD pulse; no further pulses.
REQ-028 SHALL cover: iDIG_N=4'b1101, iSEG7=7'b1111001 held 3 cycles then changed -> no write and no oUPD; oBCD[7:4] stays 4'hF.
REQ-029 SHALL cover: iDIG_N=4'b1011, iSEG7=7'b1010101 held 6 cycles -> oERR=1 from edge 5 on, oBCD[11:8]=4'hF, oVALID[2]=0; oERR stays 1 through later valid writes until iCLR.
REQ-030 SHALL cover: iDIG_N=4'b1100 and 4'b1111, each held 6 cycles with iSEG7=7'b0000000 -> no write, no oUPD, no oERR.
REQ-031 SHALL cover: scanning digits 0..3 with patterns for 7,4,9,1, each held 6 cycles -> oBCD=16'h1947, oVALID=4'b1111, and exactly four oUPD pulses.
REQ-032 SHALL cover: iCLR asserted on the acceptance cycle -> oBCD=16'hFFFF, oVALID=0, no oUPD; then iRST_N=0 mid-run for 1 cycle -> reset values, and the held input is accepted 5 edges after iRST_N rises.
